// File: rtl/lane_pkg.sv
// lane_pkg: shared definitions for the lane deskew block.
//   NUM_LANES : number of deserializer lanes being aligned
//   COM_SYM   : default alignment symbol
//   state_t   : deskew FSM states
//   com_count : number of set bits in a per-lane COM hit vector
package lane_pkg;

  localparam int         NUM_LANES = 4;
  localparam logic [7:0] COM_SYM   = 8'hBC;

  typedef enum logic {
    SEARCH  = 1'b0,
    ALIGNED = 1'b1
  } state_t;

  function automatic logic [2:0] com_count(input logic [NUM_LANES-1:0] hits);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_LANES; i++) n = n + {2'b00, hits[i]};
    return n;
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// lane_fifo: per-lane synchronous FIFO with a combinational head.
//   clk, rst  : clock, asynchronous active-high reset
//   wr_en     : push wr_data (taken when not full, or when full and popping)
//   rd_en     : pop the head (ignored when empty)
//   flush     : empty the FIFO this edge; a coincident write is dropped
//   rd_data   : current head entry (meaningless while empty)
//   empty/full: occupancy flags
module lane_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  input  logic         flush,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (r_wptr == r_rptr);
  assign full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = rd_en && !empty;
  assign w_push  = wr_en && (!full || w_pop);
  assign rd_data = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/lane_deskew.sv
// lane_deskew: four-lane receive aligner. Each lane is buffered in a
// lane_fifo; in SEARCH, lanes drop bytes until their head is COM and hold
// it until all four agree (bounded by MAX_SKEW cycles), then the block
// streams aligned sets while every lane has data.
//   clk250k, reset       : byte clock, asynchronous active-high reset
//   in_lane_N/in_valid_N : raw byte and valid per lane
//   Lane_N               : registered aligned byte per lane
//   valid_out            : Lane_N carry a new aligned set
//   lanes_aligned        : high while in ALIGNED
//   deskew_error         : one-cycle pulse on timeout, COM mismatch or overflow
module lane_deskew
  import lane_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter int         MAX_SKEW = 3,
  parameter logic [7:0] COM      = COM_SYM
) (
  input  logic       clk250k,
  input  logic       reset,
  input  logic [7:0] in_lane_0,
  input  logic [7:0] in_lane_1,
  input  logic [7:0] in_lane_2,
  input  logic [7:0] in_lane_3,
  input  logic       in_valid_0,
  input  logic       in_valid_1,
  input  logic       in_valid_2,
  input  logic       in_valid_3,
  output logic [7:0] Lane_0,
  output logic [7:0] Lane_1,
  output logic [7:0] Lane_2,
  output logic [7:0] Lane_3,
  output logic       valid_out,
  output logic       lanes_aligned,
  output logic       deskew_error
);

  localparam int               CNT_W    = $clog2(MAX_SKEW + 1);
  localparam logic [CNT_W-1:0] SKEW_LIM = CNT_W'(MAX_SKEW);

  logic [NUM_LANES-1:0][7:0] w_in_data;
  logic [NUM_LANES-1:0]      w_in_vld;
  logic [NUM_LANES-1:0][7:0] w_head;
  logic [NUM_LANES-1:0]      w_empty;
  logic [NUM_LANES-1:0]      w_full;
  logic [NUM_LANES-1:0]      w_pop;
  logic [NUM_LANES-1:0]      w_is_com;
  logic [NUM_LANES-1:0]      w_head_com;
  logic [2:0]                w_ncom;
  logic                      w_flush;
  logic                      w_fault;
  logic                      w_ovf;

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic [NUM_LANES-1:0][7:0] r_lane, w_lane_nxt;
  logic                      r_valid, w_valid_nxt;
  logic                      r_err;

  assign w_in_data = {in_lane_3, in_lane_2, in_lane_1, in_lane_0};
  assign w_in_vld  = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
      .clk    (clk250k),
      .rst    (reset),
      .wr_en  (w_in_vld[g]),
      .wr_data(w_in_data[g]),
      .rd_en  (w_pop[g]),
      .flush  (w_flush),
      .rd_data(w_head[g]),
      .empty  (w_empty[g]),
      .full   (w_full[g])
    );
    // w_is_com qualifies with occupancy; w_head_com is only consulted
    // when every lane is known non-empty.
    assign w_is_com[g]   = !w_empty[g] && (w_head[g] == COM);
    assign w_head_com[g] = (w_head[g] == COM);
  end

  assign w_ncom = com_count(w_head_com);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_pop       = '0;
    w_lane_nxt  = r_lane;
    w_valid_nxt = 1'b0;
    w_fault     = 1'b0;
    w_ovf       = 1'b0;
    w_flush     = 1'b0;

    case (r_state)
      SEARCH: begin
        if (&w_is_com) begin
          w_pop       = '1;
          w_lane_nxt  = w_head;
          w_valid_nxt = 1'b1;
          w_state_nxt = ALIGNED;
        end else begin
          // Non-COM heads are discarded; COM heads wait for the others.
          w_pop = ~w_empty & ~w_is_com;
          if (|w_is_com) begin
            if (r_cnt == SKEW_LIM) w_fault   = 1'b1;
            else                   w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ALIGNED: begin
        if (!(|w_empty)) begin
          w_pop = '1;
          // A partial COM set means the lanes have slipped.
          if (w_ncom != 3'd0 && w_ncom != 3'(NUM_LANES)) begin
            w_fault = 1'b1;
          end else begin
            w_lane_nxt  = w_head;
            w_valid_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = SEARCH;
    endcase

    // Overflow depends on this cycle's pops, so it is resolved last.
    w_ovf   = |(w_in_vld & w_full & ~w_pop);
    w_flush = w_fault | w_ovf;

    if (w_flush) begin
      w_state_nxt = SEARCH;
      w_cnt_nxt   = '0;
      w_valid_nxt = 1'b0;
      w_lane_nxt  = r_lane;
    end
  end

  always_ff @(posedge clk250k or posedge reset) begin
    if (reset) begin
      r_state <= SEARCH;
      r_cnt   <= '0;
      r_lane  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lane  <= w_lane_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_flush;
    end
  end

  assign Lane_0        = r_lane[0];
  assign Lane_1        = r_lane[1];
  assign Lane_2        = r_lane[2];
  assign Lane_3        = r_lane[3];
  assign valid_out     = r_valid;
  assign lanes_aligned = (r_state == ALIGNED);
  assign deskew_error  = r_err;

endmodule

// File: doc/lane_deskew.md
# lane_deskew

Receive-side lane aligner placed directly upstream of the byte-joining stage. It accepts one byte per lane per cycle from the four per-lane deserializers and buffers each lane in a small FIFO. It uses the COM symbol (8'hBC) to remove inter-lane skew, then presents four mutually aligned bytes on `Lane_0..Lane_3` for byte joining to interleave.

## Interface
- `DEPTH`, 4: per-lane FIFO depth in bytes (power of two, ≥ 4)
- `MAX_SKEW`, 3: maximum tolerated skew in cycles between first and last lane presenting COM
- `COM`, 8'hBC: alignment symbol
- `clk250k`  in  1  lane byte clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high; one clock, asynchronous active-high reset
- `in_lane_0..in_lane_3`  in  8 each  raw bytes from the deserializers
- `in_valid_0..in_valid_3`  in  1 each  byte on corresponding `in_lane_i` is valid this cycle
- `Lane_0..Lane_3`  out  8 each  aligned bytes to byte joining (registered)
- `valid_out`  out  1  `Lane_*` carry a new aligned set this cycle
- `lanes_aligned`  out  1  level; high while in ALIGNED
- `deskew_error`  out  1  one-cycle pulse on skew timeout, COM mismatch or FIFO overflow

## Operation
- Per lane: write `in_lane_i` into FIFO i when `in_valid_i`. Read and write on the same cycle is legal at any fill level, including full.
- Overflow occurs when a write hits a full FIFO with no read that cycle. Response: `deskew_error` pulse, flush all FIFOs, skew counter cleared, go to SEARCH.
- FSM states: SEARCH, ALIGNED.
- SEARCH:
  - Each lane whose head is non-empty and ≠ COM pops and discards its head.
  - A lane whose head = COM holds it.
  - The skew counter starts at 1 on the first cycle any lane holds COM. It increments each further cycle until all four lanes hold COM.
  - If the counter would exceed `MAX_SKEW`: `deskew_error` pulse, flush all FIFOs, counter to 0, remain in SEARCH.
  - When all four heads = COM: pop all four, register them to `Lane_*`, `valid_out`=1, go to ALIGNED, `lanes_aligned`=1.
- ALIGNED:
  - If all four FIFOs are non-empty, pop all four, register them to `Lane_*`, `valid_out`=1.
  - Otherwise `valid_out`=0, `Lane_*` hold, and nothing is popped.
  - If a popped set has COM on 1–3 lanes (not 0, not 4), that set is discarded: `valid_out`=0, `deskew_error` pulse, `lanes_aligned`=0, flush, go to SEARCH.
- Flush empties all FIFOs in one cycle. Writes arriving on the flush cycle are dropped.
- Error priority when events coincide: overflow = COM mismatch = timeout. All three produce the same single-cycle pulse and the same flush.

## Timing
- Reset values: `Lane_*`=8'h00, `valid_out`=0, `lanes_aligned`=0, `deskew_error`=0, FSM=SEARCH, FIFOs empty, skew counter=0.
- FIFO write at edge t is visible at the head after edge t; a pop on the next cycle registers the output at edge t+1. Minimum latency from input to `Lane_*` is 2 cycles.
- Zero-skew alignment: COM written on all lanes at edge t gives `valid_out`=1 with `Lane_*`=BC after edge t+1.
- Outputs are glitch-free registers. `deskew_error` is never high for two consecutive cycles unless two separate errors occur.
- Reset assertion mid-stream returns everything to reset values immediately (asynchronously). Operation resumes in SEARCH after deassertion.

## Structure
- Shared package `lane_pkg`: `COM` default, FSM state typedef {SEARCH, ALIGNED}, lane count constant 4.
- Sub-module `lane_fifo`, instantiated 4×: synchronous FIFO parameterized by `DEPTH`. Ports: wr_en, wr_data, rd_en, flush, rd_data (head), empty, full.
- Top contains the FSM, skew counter, COM compare, and output registers.

## Test plan
- Zero skew: all lanes send BC,01,02,03 from cycle 0 -> `valid_out` from cycle 2, `Lane_*`=BC then 01,02,03 on all lanes; `lanes_aligned`=1; no error.
- Skew 2: lane 2 delayed 2 cycles, others as above -> `Lane_*` identical on all lanes (BC,01,02,03); `lanes_aligned`=1 after lane 2's COM arrives.
- Skew 4 > `MAX_SKEW`: lane 1 delayed 4 cycles -> single `deskew_error` pulse, FIFOs flushed, realignment on the next common COM.
- COM mismatch: aligned stream, then lanes 0–1 send BC while lanes 2–3 send 55 -> that set is not output, `deskew_error` pulse, `lanes_aligned`=0.
- Gap/overflow: in ALIGNED, drop `in_valid_3` for 1 cycle -> `valid_out`=0 that cycle with no error. Then hold lane 3 low for `DEPTH`+1 cycles while the other lanes stream -> overflow error pulse and return to SEARCH.
- Reset mid-operation: assert `reset` while `valid_out`=1 -> all outputs 00/0 immediately. After release, zero-skew stimulus realigns as in scenario 1.
